tdm_demux: RTL
==============

Name: tdm_demux

Overview:
- Receive-side demultiplexer for a time-division-multiplexed sample stream.
- A transmitter selects one channel per slot onto a shared bus. This block rebuilds the per-channel values from that bus.
- A slot counter, locked by a frame-sync marker, steers each valid sample into a staging register.
- Complete frames are committed atomically to the output bank. Downstream logic therefore never sees a half-updated frame.

Parameters:
- NUM_CH, 4, number of channels (slots) per frame; legal range 2..16.
- WIDTH, 8, bits per sample.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  TDM sample bus.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks slot 0 of a frame.
- frame_out  output  NUM_CH*WIDTH  committed frame; channel k occupies bits [k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse when frame_out has just been updated.
- locked  output  1  high while in RECEIVE state.
- slot  output  clog2(NUM_CH)  index of the next expected slot.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (asynchronous, active-high) clears all outputs and internal state:
  - frame_out = 0, staging = 0.
  - frame_valid = 0, sync_err = 0, locked = 0, slot = 0.
  - State = HUNT.
- Cycles with din_valid = 0 change nothing. frame_sync is ignored when din_valid = 0.
- All outputs are registered. Effects appear on the clock edge that samples the input.
- HUNT state:
  - din_valid && !frame_sync: sample discarded, no error, stay in HUNT.
  - din_valid && frame_sync: staging[0] <= din, slot <= 1, go to RECEIVE, locked <= 1.
- RECEIVE state, slot = s, with s != 0:
  - din_valid && !frame_sync: staging[s] <= din.
    - If s < NUM_CH-1: slot <= s+1.
    - If s = NUM_CH-1: frame_out <= staging with the slot NUM_CH-1 field replaced by din (same edge), frame_valid <= 1, slot <= 0.
  - din_valid && frame_sync: early sync. sync_err <= 1, partial frame abandoned, frame_out unchanged. The sample is taken as slot 0 of a new frame: staging[0] <= din, slot <= 1, stay in RECEIVE.
- RECEIVE state, slot = 0 (frame boundary):
  - din_valid && frame_sync: staging[0] <= din, slot <= 1.
  - din_valid && !frame_sync: missing sync. sync_err <= 1, sample discarded, go to HUNT, locked <= 0, slot <= 0.
- frame_valid and sync_err are single-cycle pulses. They are never high together.
- Staging contents from abandoned frames are never committed. Stale staging entries are overwritten before the next commit.
- frame_out holds its value between commits. It changes only on frame_valid, and never on an error.
- Back-to-back samples every cycle are supported: one frame every NUM_CH valid cycles, with no bubbles required.
- Reset asserted mid-frame takes effect immediately. Partial staging is discarded and the block returns to HUNT.

Test Plan:
(NUM_CH=4, WIDTH=8 unless stated.)
- Basic frame: reset, then valid samples 0x11(sync), 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: frame_valid pulses exactly once on the 4th edge.
  - Required: frame_out = 0x44332211, locked = 1, slot = 0.
- Hunt discard: valid samples 0xAA, 0xBB without sync, then 0x01(sync), 0x02, 0x03, 0x04.
  - Required: no sync_err, locked rises on the 0x01 edge.
  - Required: frame_out = 0x04030201.
- Early sync: 0x11(sync), 0x22, 0x55(sync), 0x66, 0x77, 0x88.
  - Required: sync_err pulses on the 0x55 edge, frame_out unchanged at that edge.
  - Required: then frame_out = 0x88776655.
- Missing sync: complete frame 0x04030201, then 0x99 without sync.
  - Required: sync_err pulses, locked = 0, frame_out stays 0x04030201.
  - Required: following non-sync samples are silently dropped.
- Gapped input and mid-frame reset: frame delivered with din_valid low for 1–3 cycles between slots produces the same frame_out as gap-free delivery. Assert rst after slot 2 of a frame.
  - Required: all outputs = 0 immediately (asynchronous), state = HUNT.
  - Required: the next synced frame commits correctly.

Source files
------------

// File: rtl/tdm_demux.sv
// TDM receive demux: frame-sync locked slot counter steers samples into staging, full frames commit atomically.
// Latency: every output is registered and updates on the edge that samples the input; a frame commits on its last-slot edge.
// Backpressure: none. Accepts one sample per cycle whenever din_valid is high; idle cycles freeze all state.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_sync,
    output logic [NUM_CH*WIDTH-1:0]   frame_out,
    output logic                      frame_valid,
    output logic                      locked,
    output logic [$clog2(NUM_CH)-1:0] slot,
    output logic                      sync_err
);

    localparam int SW = $clog2(NUM_CH);
    localparam int FW = NUM_CH * WIDTH;
    localparam logic [SW-1:0] SLOT_FIRST = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_CH - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   slot_nxt;
    logic [FW-1:0]   staging, staging_nxt;
    logic [FW-1:0]   frame_out_nxt;
    logic            frame_valid_nxt;
    logic            sync_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= '0;
            staging     <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            staging     <= staging_nxt;
            frame_out   <= frame_out_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
            locked      <= (state_nxt == RECEIVE);
        end
    end

    always_comb begin
        state_nxt       = state;
        slot_nxt        = slot;
        staging_nxt     = staging;
        frame_out_nxt   = frame_out;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;

        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        staging_nxt[WIDTH-1:0] = din;
                        slot_nxt               = SLOT_FIRST;
                        state_nxt              = RECEIVE;
                    end
                end

                RECEIVE: begin
                    if (frame_sync) begin
                        // A sync mid-frame abandons the partial frame but still starts a new one.
                        sync_err_nxt           = (slot != '0);
                        staging_nxt[WIDTH-1:0] = din;
                        slot_nxt               = SLOT_FIRST;
                    end else if (slot == '0) begin
                        sync_err_nxt = 1'b1;
                        slot_nxt     = '0;
                        state_nxt    = HUNT;
                    end else begin
                        staging_nxt[int'(slot)*WIDTH +: WIDTH] = din;
                        if (slot == SLOT_LAST) begin
                            // Last slot bypasses staging so the commit happens on this same edge.
                            frame_out_nxt                                = staging;
                            frame_out_nxt[(NUM_CH-1)*WIDTH +: WIDTH]     = din;
                            frame_valid_nxt                              = 1'b1;
                            slot_nxt                                     = '0;
                        end else begin
                            slot_nxt = slot + SW'(1);
                        end
                    end
                end

                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = '0;
                end
            endcase
        end
    end

endmodule
